// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the memory BIST engine: 16-state TAP FSM, 4-bit IR,
// IDCODE / signature / address-range / bypass data chains, negedge TDO.
module jtag_tap_ctrl #(
   parameter logic [31:0] IDCODE_VAL = 32'h1BE5_7001,
   parameter logic [3:0]  IR_RESET   = 4'b0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tms,
   input  logic        tdi,
   output logic        tdo,
   output logic        tdo_en,
   input  logic [13:0] signature,
   output logic        runbist_en,
   output logic        idle_en,
   output logic [7:0]  start_addr,
   output logic [7:0]  end_addr
);

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_e;

   localparam logic [3:0] OP_IDCODE     = 4'b0001;
   localparam logic [3:0] OP_SIG_READ   = 4'b0011;
   localparam logic [3:0] OP_ADDR_RANGE = 4'b0101;
   localparam logic [3:0] OP_RUNBIST    = 4'b0111;

   tap_state_e  state_q, state_d;
   logic [3:0]  ir_q, ir_d;
   logic [3:0]  ir_sr_q, ir_sr_d;
   logic [31:0] id_sr_q, id_sr_d;
   logic [13:0] sig_sr_q, sig_sr_d;
   logic [15:0] addr_sr_q, addr_sr_d;
   logic        byp_q, byp_d;
   logic [7:0]  start_q, start_d;
   logic [7:0]  end_q, end_d;
   logic        tdo_q, tdo_d;
   logic        tdo_en_q, tdo_en_d;

   logic sel_id, sel_sig, sel_addr;
   assign sel_id   = (ir_q == OP_IDCODE);
   assign sel_sig  = (ir_q == OP_SIG_READ);
   assign sel_addr = (ir_q == OP_ADDR_RANGE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= TLR;
         ir_q      <= IR_RESET;
         ir_sr_q   <= '0;
         id_sr_q   <= '0;
         sig_sr_q  <= '0;
         addr_sr_q <= '0;
         byp_q     <= 1'b0;
         start_q   <= 8'h00;
         end_q     <= 8'hFF;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         ir_sr_q   <= ir_sr_d;
         id_sr_q   <= id_sr_d;
         sig_sr_q  <= sig_sr_d;
         addr_sr_q <= addr_sr_d;
         byp_q     <= byp_d;
         start_q   <= start_d;
         end_q     <= end_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = tms ? TLR    : RTI;
         RTI:    state_d = tms ? SEL_DR : RTI;
         SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR: state_d = tms ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms ? SEL_DR : RTI;
         SEL_IR: state_d = tms ? TLR    : CAP_IR;
         CAP_IR: state_d = tms ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR: state_d = tms ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   // Only the chain selected by the current IR captures, shifts or updates.
   always_comb begin
      ir_d      = ir_q;
      ir_sr_d   = ir_sr_q;
      id_sr_d   = id_sr_q;
      sig_sr_d  = sig_sr_q;
      addr_sr_d = addr_sr_q;
      byp_d     = byp_q;
      start_d   = start_q;
      end_d     = end_q;
      case (state_q)
         TLR:    ir_d    = IR_RESET;
         CAP_IR: ir_sr_d = 4'b0001;
         SH_IR:  ir_sr_d = {tdi, ir_sr_q[3:1]};
         UPD_IR: ir_d    = ir_sr_q;
         CAP_DR: begin
            if (sel_id)        id_sr_d   = IDCODE_VAL;
            else if (sel_sig)  sig_sr_d  = signature;
            else if (sel_addr) addr_sr_d = {end_q, start_q};
            else               byp_d     = 1'b0;
         end
         SH_DR: begin
            if (sel_id)        id_sr_d   = {tdi, id_sr_q[31:1]};
            else if (sel_sig)  sig_sr_d  = {tdi, sig_sr_q[13:1]};
            else if (sel_addr) addr_sr_d = {tdi, addr_sr_q[15:1]};
            else               byp_d     = tdi;
         end
         UPD_DR: begin
            if (sel_addr) begin
               start_d = addr_sr_q[7:0];
               end_d   = addr_sr_q[15:8];
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
      if (state_q == SH_IR) begin
         tdo_d    = ir_sr_q[0];
         tdo_en_d = 1'b1;
      end else if (state_q == SH_DR) begin
         tdo_en_d = 1'b1;
         if (sel_id)        tdo_d = id_sr_q[0];
         else if (sel_sig)  tdo_d = sig_sr_q[0];
         else if (sel_addr) tdo_d = addr_sr_q[0];
         else               tdo_d = byp_q;
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign tdo        = tdo_q;
   assign tdo_en     = tdo_en_q;
   assign runbist_en = (ir_q == OP_RUNBIST);
   assign idle_en    = (state_q == RTI);
   assign start_addr = start_q;
   assign end_addr   = end_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl; stimulus queues expected TDO bits and
// status values, independent monitor processes pop and compare them.
module tb_jtag_tap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tms = 1'b1;
   logic        tdi = 1'b0;
   logic        tdo;
   logic        tdo_en;
   logic [13:0] signature = '0;
   logic        runbist_en;
   logic        idle_en;
   logic [7:0]  start_addr;
   logic [7:0]  end_addr;

   jtag_tap_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tms        (tms),
      .tdi        (tdi),
      .tdo        (tdo),
      .tdo_en     (tdo_en),
      .signature  (signature),
      .runbist_en (runbist_en),
      .idle_en    (idle_en),
      .start_addr (start_addr),
      .end_addr   (end_addr)
   );

   always #5 clk = ~clk;

   localparam int K_TDO = 0, K_TDO_EN = 1, K_IDLE = 2, K_RUNBIST = 3, K_START = 4, K_END = 5;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } chk_t;

   chk_t chk_q[$];
   logic tdo_q[$];
   event chk_ev;
   int   n_checks = 0;
   int   n_passed = 0;
   int   tdo_idx  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic expect_sig(input string name, input int kind, input logic [31:0] v);
      chk_t c;
      c.name = name;
      c.kind = kind;
      c.exp  = v;
      chk_q.push_back(c);
      -> chk_ev;
   endtask

   task automatic push_bits(input int n, input logic [31:0] v);
      for (int i = 0; i < n; i++) tdo_q.push_back(v[i]);
   endtask

   task automatic tick(input logic tms_v, input logic tdi_v);
      tms = tms_v;
      tdi = tdi_v;
      @(posedge clk);
      #2;
   endtask

   task automatic load_ir(input logic [3:0] op);
      push_bits(4, 32'h1);
      tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
      for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
      tick(1, 0); tick(0, 0);
   endtask

   task automatic goto_shift_dr();
      tick(1, 0); tick(0, 0); tick(0, 0);
   endtask

   task automatic shift_dr(input int n, input logic [31:0] din);
      for (int i = 0; i < n; i++) tick(i == n - 1, din[i]);
   endtask

   task automatic update_to_idle();
      tick(1, 0); tick(0, 0);
   endtask

   // Status monitor
   initial begin
      forever begin
         @(chk_ev);
         while (chk_q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c = chk_q.pop_front();
            case (c.kind)
               K_TDO:     act = {31'b0, tdo};
               K_TDO_EN:  act = {31'b0, tdo_en};
               K_IDLE:    act = {31'b0, idle_en};
               K_RUNBIST: act = {31'b0, runbist_en};
               K_START:   act = {24'b0, start_addr};
               default:   act = {24'b0, end_addr};
            endcase
            check(c.name, act, c.exp);
         end
      end
   end

   // TDO monitor
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (tdo_en) begin
            if (tdo_q.size() == 0) begin
               check("tdo_unexpected", {31'b0, tdo_en}, 32'h0);
            end else begin
               logic e;
               e = tdo_q.pop_front();
               check($sformatf("tdo_bit%0d", tdo_idx), {31'b0, tdo}, {31'b0, e});
               tdo_idx++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #12;
      expect_sig("rst_tdo", K_TDO, 0);
      expect_sig("rst_tdo_en", K_TDO_EN, 0);
      expect_sig("rst_idle", K_IDLE, 0);
      expect_sig("rst_runbist", K_RUNBIST, 0);
      expect_sig("rst_start", K_START, 8'h00);
      expect_sig("rst_end", K_END, 8'hFF);
      #5 rst_n = 1'b1;

      // TLR -> RTI, IDCODE scan
      tick(0, 0);
      expect_sig("rti_idle", K_IDLE, 1);
      expect_sig("rti_runbist", K_RUNBIST, 0);
      push_bits(32, 32'h1BE5_7001);
      goto_shift_dr();
      shift_dr(32, 32'h0);
      update_to_idle();

      // BYPASS loaded, five TMS=1 from Shift-DR reaches TLR and resets IR
      load_ir(4'b1111);
      push_bits(1, 32'h0);
      goto_shift_dr();
      for (int i = 0; i < 5; i++) tick(1, 0);
      expect_sig("tlr_idle", K_IDLE, 0);
      expect_sig("tlr_start", K_START, 8'h00);
      expect_sig("tlr_end", K_END, 8'hFF);
      tick(0, 0);
      expect_sig("tlr_rti_idle", K_IDLE, 1);
      push_bits(32, 32'h1BE5_7001);
      goto_shift_dr();
      shift_dr(32, 32'hFFFF_FFFF);
      update_to_idle();

      // ADDR_RANGE write and re-scan
      load_ir(4'b0101);
      push_bits(16, 32'hFF00);
      goto_shift_dr();
      shift_dr(16, 32'h9F40);
      update_to_idle();
      expect_sig("addr_start", K_START, 8'h40);
      expect_sig("addr_end", K_END, 8'h9F);
      push_bits(16, 32'h9F40);
      goto_shift_dr();
      shift_dr(16, 32'h9F40);
      update_to_idle();
      expect_sig("addr_start2", K_START, 8'h40);
      expect_sig("addr_end2", K_END, 8'h9F);

      // RUNBIST parked in RTI
      load_ir(4'b0111);
      for (int i = 0; i < 50; i++) begin
         tick(0, 0);
         expect_sig($sformatf("rb_runbist_c%0d", i), K_RUNBIST, 1);
         expect_sig($sformatf("rb_idle_c%0d", i), K_IDLE, 1);
      end
      tick(1, 0);
      expect_sig("rb_exit_idle", K_IDLE, 0);
      expect_sig("rb_exit_runbist", K_RUNBIST, 1);
      for (int i = 0; i < 5; i++) tick(1, 0);
      expect_sig("tlr2_runbist", K_RUNBIST, 0);
      expect_sig("tlr2_start", K_START, 8'h40);
      expect_sig("tlr2_end", K_END, 8'h9F);
      tick(0, 0);

      // SIG_READ: capture-time value only
      load_ir(4'b0011);
      signature = 14'h2A5C;
      push_bits(14, 32'h2A5C);
      goto_shift_dr();
      signature = 14'h1234;
      shift_dr(14, 32'h0);
      update_to_idle();

      // Undefined opcode acts as bypass, then reset mid-shift
      load_ir(4'b1010);
      push_bits(6, 32'b10_0100);
      goto_shift_dr();
      for (int i = 0; i < 6; i++) tick(0, (8'b1011_0010 >> i) & 1);
      rst_n = 1'b0;
      #1;
      expect_sig("mid_rst_tdo", K_TDO, 0);
      expect_sig("mid_rst_tdo_en", K_TDO_EN, 0);
      expect_sig("mid_rst_idle", K_IDLE, 0);
      expect_sig("mid_rst_runbist", K_RUNBIST, 0);
      expect_sig("mid_rst_start", K_START, 8'h00);
      expect_sig("mid_rst_end", K_END, 8'hFF);
      #20;
      rst_n = 1'b1;
      tick(1, 0);
      tick(1, 0);
      #10;
      check("tdo_queue_drained", tdo_q.size(), 0);
      check("chk_queue_drained", chk_q.size(), 0);
      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that fronts the memory BIST engine. It decodes TMS into the 16-state TAP state machine and holds a 4-bit instruction register. It drives the `runbist_en` / `idle_en` pair consumed by `BIST_FSM`, and provides a scan-writable address-range register for `start_addr` / `end_addr`. It captures the 14-bit BIST `signature` into a data register shifted out on TDO.

## Interface
Parameters:
- `IDCODE_VAL`, default 32'h1BE5_7001, value captured by the IDCODE chain; bit 0 must be 1.
- `IR_RESET`, default 4'b0001, IR contents after reset and in Test-Logic-Reset (the IDCODE opcode).

Ports:
- `clk`  in  1  TCK. Single clock; posedge for state, IR and DR updates, negedge for TDO only.
- `rst_n`  in  1  TRST_N. Asynchronous, active-low.
- `tms`  in  1  test mode select, sampled on posedge `clk`.
- `tdi`  in  1  test data in, sampled on posedge `clk`.
- `tdo`  out  1  test data out, registered on negedge `clk`.
- `tdo_en`  out  1  high while TDO is valid (Shift-IR / Shift-DR).
- `signature`  in  14  BIST result, captured in Capture-DR under SIG_READ.
- `runbist_en`  out  1  IR == RUNBIST.
- `idle_en`  out  1  TAP state == Run-Test/Idle.
- `start_addr`  out  8  first BIST address.
- `end_addr`  out  8  last BIST address, inclusive.

## Operation
- TAP FSM: the 16 standard states (TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the IR equivalents). Transitions follow the standard TMS table exactly.
  - TLR with TMS=0 goes to RTI.
  - Five consecutive TMS=1 reach TLR from any state.
- IR, 4 bits:
  - Capture-IR loads 4'b0001 into the IR shift register.
  - Shift-IR shifts LSB-first: `ir_sr <= {tdi, ir_sr[3:1]}`.
  - Update-IR copies the shift register into the IR.
  - In TLR, IR is forced to `IR_RESET`.
- Opcodes and selected DR chains:
  - IDCODE 4'b0001: 32-bit chain, captures `IDCODE_VAL`.
  - SIG_READ 4'b0011: 14-bit chain, captures `signature`.
  - ADDR_RANGE 4'b0101: 16-bit chain, captures {end_addr, start_addr}. Update-DR writes `start_addr` = sr[7:0] and `end_addr` = sr[15:8].
  - RUNBIST 4'b0111: bypass chain.
  - BYPASS 4'b1111, and every other code: 1-bit chain, captures 0.
- DR shifting is LSB-first; TDI enters at the MSB of the selected chain. Only the selected chain shifts. Other chains hold.
- Only ADDR_RANGE has an update effect. SIG_READ and IDCODE are capture-only.
- `runbist_en` and `idle_en` are combinational decodes of registered IR and state. The BIST runs only while RUNBIST is loaded and the TAP parks in RTI.
  - Any TMS=1 out of RTI drops `idle_en` and returns `BIST_FSM` to its idle state.
  - The signature is preserved there, so a following SIG_READ scan reads the final result.
- `start_addr` and `end_addr` are not range-checked. start > end is legal; the BIST then reports done immediately.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=TLR, IR=`IR_RESET`, all shift registers 0.
  - `start_addr`=8'h00, `end_addr`=8'hFF.
  - `tdo`=0, `tdo_en`=0, `runbist_en`=0, `idle_en`=0.
- Reset mid-scan aborts the scan. No IR or DR update occurs.
- Entering TLR synchronously resets IR only. `start_addr` and `end_addr` persist.
- Capture happens on the posedge that leaves the Capture state. Shift happens on each posedge while in a Shift state, including the posedge that exits to Exit1. Update happens on the posedge that leaves the Update state.
- TDO:
  - On negedge in Shift-IR: `tdo` = ir_sr[0], `tdo_en`=1.
  - On negedge in Shift-DR: `tdo` = sr[0] of the selected chain, `tdo_en`=1.
  - Otherwise `tdo`=0, `tdo_en`=0.
  - The first bit out is the captured LSB, valid half a cycle after entering Shift.
- Chain latency TDI→TDO equals the chain length: 1 for bypass, 14, 16, 32, and 4 for IR.
- `signature` is sampled only at Capture-DR. Changes during shift are ignored.
- `idle_en` rises one posedge after TMS=0 is sampled in Update-IR/Update-DR or in TLR.

## Test plan
- Reset, then TMS=0 for one cycle: state RTI, `idle_en`=1, `runbist_en`=0. A DR scan shifts out 32'h1BE5_7001 LSB-first.
- From Shift-DR, apply five TMS=1: state TLR. IR reads 4'b0001. `start_addr`/`end_addr` are unchanged from before.
- Load IR 4'b0101, shift DR 16'h9F40, update: `start_addr`=8'h40, `end_addr`=8'h9F. A re-scan shifts out 16'h9F40.
- Load RUNBIST, park in RTI for 50 cycles: `runbist_en`=1 and `idle_en`=1 throughout. TMS=1 gives `idle_en`=0 on the next posedge.
- Load SIG_READ with `signature`=14'h2A5C at Capture-DR, then change `signature` during shift: TDO emits 14'h2A5C LSB-first.
- Load 4'b1010 (undefined), shift 8'b1011_0010: TDO equals TDI delayed by one cycle; the first TDO bit is 0. Assert `rst_n` mid-shift: all outputs return to their reset values immediately.
